// File: rtl/step_sequencer.sv
// Pattern step sequencer: plays a STEPS-entry note/voice-mask pattern, one step every
// step_ticks audio samples, with a per-step gate window of gate_ticks samples.
module step_sequencer #(
  parameter int unsigned STEPS      = 16,
  parameter logic [7:0]  NOTE_RESET = 8'd60,
  localparam int unsigned AW        = $clog2(STEPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_tick,
  input  logic          run,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [11:0]   wr_data,
  input  logic [AW-1:0] last_step,
  input  logic [15:0]   step_ticks,
  input  logic [15:0]   gate_ticks,
  output logic [3:0]    gate,
  output logic [7:0]    note0,
  output logic [7:0]    note1,
  output logic [7:0]    note2,
  output logic [7:0]    note3,
  output logic [AW-1:0] step_idx,
  output logic          step_strobe
);

  typedef enum logic [1:0] {StIdle, StOn, StRest} state_e;

  state_e          r_state;
  logic [3:0]      r_gate;
  logic [3:0][7:0] r_notes;
  logic [AW-1:0]   r_step_idx;
  logic            r_strobe;
  logic [15:0]     r_tick_cnt;
  logic [11:0]     r_pattern [STEPS];

  state_e          w_state_nxt;
  logic [3:0]      w_gate_nxt;
  logic [3:0][7:0] w_notes_nxt;
  logic [AW-1:0]   w_idx_nxt;
  logic            w_strobe_nxt;
  logic [15:0]     w_cnt_nxt;
  logic            w_load;
  logic [AW-1:0]   w_load_idx;
  logic [11:0]     w_entry;

  logic [15:0]     w_tick_inc;
  logic [15:0]     w_step_len;
  logic            w_step_end;
  logic [AW-1:0]   w_wrap_idx;

  assign w_tick_inc = r_tick_cnt + 16'd1;
  assign w_step_len = (step_ticks == 16'd0) ? 16'd1 : step_ticks;
  assign w_step_end = (w_tick_inc == w_step_len);
  // An index already past a lowered last_step also wraps to 0.
  assign w_wrap_idx = (r_step_idx >= last_step) ? '0 : r_step_idx + 1'b1;
  assign w_entry    = r_pattern[w_load_idx];

  always_comb begin
    w_state_nxt  = r_state;
    w_gate_nxt   = r_gate;
    w_notes_nxt  = r_notes;
    w_idx_nxt    = r_step_idx;
    w_strobe_nxt = 1'b0;
    w_cnt_nxt    = r_tick_cnt;
    w_load       = 1'b0;
    w_load_idx   = '0;

    unique case (r_state)
      StIdle: begin
        w_gate_nxt = '0;
        w_cnt_nxt  = '0;
        w_idx_nxt  = '0;
        if (run && sample_tick) begin
          w_load     = 1'b1;
          w_load_idx = '0;
        end
      end
      StOn, StRest: begin
        if (!run) begin
          w_state_nxt = StIdle;
          w_gate_nxt  = '0;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (sample_tick) begin
          if (w_step_end) begin
            w_load     = 1'b1;
            w_load_idx = w_wrap_idx;
          end else begin
            w_cnt_nxt = w_tick_inc;
            if (r_state == StOn && w_tick_inc == gate_ticks) begin
              w_gate_nxt  = '0;
              w_state_nxt = StRest;
            end
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // Step load reads the pre-write entry; the tie across steps falls out of reloading gates.
    if (w_load) begin
      for (int v = 0; v < 4; v++) begin
        if (w_entry[8+v]) w_notes_nxt[v] = w_entry[7:0];
        w_gate_nxt[v] = w_entry[8+v] && (gate_ticks != 16'd0);
      end
      w_strobe_nxt = 1'b1;
      w_cnt_nxt    = '0;
      w_idx_nxt    = w_load_idx;
      w_state_nxt  = (gate_ticks == 16'd0) ? StRest : StOn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_gate     <= '0;
      r_notes    <= {4{NOTE_RESET}};
      r_step_idx <= '0;
      r_strobe   <= 1'b0;
      r_tick_cnt <= '0;
      for (int i = 0; i < STEPS; i++) r_pattern[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gate     <= w_gate_nxt;
      r_notes    <= w_notes_nxt;
      r_step_idx <= w_idx_nxt;
      r_strobe   <= w_strobe_nxt;
      r_tick_cnt <= w_cnt_nxt;
      if (wr_en) r_pattern[wr_addr] <= wr_data;
    end
  end

  assign gate        = r_gate;
  assign note0       = r_notes[0];
  assign note1       = r_notes[1];
  assign note2       = r_notes[2];
  assign note3       = r_notes[3];
  assign step_idx    = r_step_idx;
  assign step_strobe = r_strobe;

endmodule
